// File: rtl/register_bank_if.sv
// Write/read bus for register_bank.
//   ctrl_writeEnable : write request
//   ctrl_writeReg    : destination register index
//   data_writeReg    : write data
//   reg_q            : flat register contents, word i at [32*i+31:32*i]
//   write_pending    : a write is held in the pending stage
//   wr_count         : saturating count of committed writes
// master drives writes (requester), slave is the register bank.
interface register_bank_if;
  logic           ctrl_writeEnable;
  logic [4:0]     ctrl_writeReg;
  logic [31:0]    data_writeReg;
  logic [1023:0]  reg_q;
  logic           write_pending;
  logic [15:0]    wr_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  reg_q, write_pending, wr_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output reg_q, write_pending, wr_count
  );
endinterface

// File: rtl/register_bank.sv
// 32 x 32-bit register bank with a one-deep pending write stage.
// A write is captured into the pending stage on one edge and committed to
// the array on the next; register 0 is hardwired to zero and writes to it
// are dropped before they reach the pending stage.
// Ports:
//   clock      : rising-edge clock
//   ctrl_reset : synchronous active-high reset
//   bus        : register_bank_if.slave (write request in, contents/status out)
// Build option: define REGBANK_BYPASS_EN to forward the pending write onto
// reg_q, making a write visible one edge earlier.
module register_bank (
  input  logic           clock,
  input  logic           ctrl_reset,
  register_bank_if.slave bus
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned CNT_W    = 16;

  // Only indices 1..31 have storage; word 0 is a constant zero.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  logic              pend_valid;
  logic [IDX_W-1:0]  pend_idx;
  logic [DATA_W-1:0] pend_data;
  logic [CNT_W-1:0]  wr_count_q;

  logic              accept_c;

  assign accept_c = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);

  // Pending stage: capture one accepted write per edge.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= accept_c;
      if (accept_c) begin
        pend_idx  <= bus.ctrl_writeReg;
        pend_data <= bus.data_writeReg;
      end
    end
  end

  // Commit stage: retire the pending write into the array.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (pend_valid) begin
      regs[pend_idx] <= pend_data;
      if (wr_count_q != '1) begin
        wr_count_q <= wr_count_q + CNT_W'(1);
      end
    end
  end

  // Flatten the array onto reg_q (optionally forwarding the pending write).
  always_comb begin
    bus.reg_q = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      bus.reg_q[DATA_W*i +: DATA_W] = regs[i];
`ifdef REGBANK_BYPASS_EN
      if (pend_valid && (pend_idx == IDX_W'(i))) begin
        bus.reg_q[DATA_W*i +: DATA_W] = pend_data;
      end
`endif
    end
  end

  assign bus.write_pending = pend_valid;
  assign bus.wr_count      = wr_count_q;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank. The driver pushes the expected commit
// (index, data, resulting wr_count) for every write that should land; the
// monitor pops an entry on every cycle after write_pending was seen and
// compares the committed word, wr_count and the whole array against a model.
module tb_register_bank;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic [15:0] cnt;
    bit          chk;
  } exp_t;

  logic clock;
  logic ctrl_reset;

  register_bank_if bus ();

  register_bank dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t           exp_q [$];
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [15:0]    exp_cnt = '0;
  logic [1023:0]  model = '0;
  bit             pend_seen = 1'b0;
  bit             rst_seen  = 1'b0;

  task automatic check(input string nm, input logic [1023:0] got, input logic [1023:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [1023:0] v, input int i);
    return v[32*i +: 32];
  endfunction

  // Monitor: commits show up one negedge after write_pending was observed.
  always @(negedge clock) begin
    exp_t e;
    if (rst_seen) begin
      model = '0;
    end else if (pend_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_commit: got commit want none");
      end else begin
        e = exp_q.pop_front();
        model[32*e.idx +: 32] = e.data;
        if (e.chk) begin
          check("commit_word", 1024'(word_of(bus.reg_q, int'(e.idx))), 1024'(e.data));
          check("commit_count", 1024'(bus.wr_count), 1024'(e.cnt));
          check("commit_array", bus.reg_q, model);
        end
      end
    end
    pend_seen = bus.write_pending;
    rst_seen  = ctrl_reset;
    // While a write is pending, its word shows the forwarded or old value.
    if (bus.write_pending && !ctrl_reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pending: got pending want idle");
      end else if (exp_q[0].chk) begin
`ifdef REGBANK_BYPASS_EN
        check("pending_word", 1024'(word_of(bus.reg_q, int'(exp_q[0].idx))), 1024'(exp_q[0].data));
`else
        check("pending_word", 1024'(word_of(bus.reg_q, int'(exp_q[0].idx))),
              1024'(word_of(model, int'(exp_q[0].idx))));
`endif
      end
    end
  end

  // Drive one write for a single edge; push the expected commit if it lands.
  task automatic wr(input logic [4:0] idx, input logic [31:0] d, input bit push, input bit chk);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = idx;
    bus.data_writeReg    = d;
    if (push && idx != 5'd0) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      exp_q.push_back('{idx: idx, data: d, cnt: exp_cnt, chk: chk});
    end
    @(posedge clock);
    #1;
    bus.ctrl_writeEnable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic check_idle_state(input string nm);
    @(negedge clock);
    check({nm, "_regq"},    bus.reg_q, '0);
    check({nm, "_pending"}, 1024'(bus.write_pending), '0);
    check({nm, "_count"},   1024'(bus.wr_count), '0);
  endtask

  initial begin
    ctrl_reset           = 1'b1;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    check_idle_state("reset");

    // Single write to index 5.
    wr(5'd5, 32'hDEADBEEF, 1'b1, 1'b1);
    @(negedge clock);
    check("w5_pending", 1024'(bus.write_pending), 1024'(1'b1));
    idle(2);
    @(negedge clock);
    check("w5_count", 1024'(bus.wr_count), 1024'(16'd1));
    check("w5_word", 1024'(word_of(bus.reg_q, 5)), 1024'(32'hDEADBEEF));

    // Write to index 0 is dropped.
    wr(5'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
    @(negedge clock);
    check("w0_pending", 1024'(bus.write_pending), '0);
    idle(1);
    @(negedge clock);
    check("w0_word", 1024'(word_of(bus.reg_q, 0)), '0);
    check("w0_count", 1024'(bus.wr_count), 1024'(16'd1));

    // Back-to-back, same index then a new one.
    wr(5'd7, 32'h1, 1'b1, 1'b1);
    wr(5'd7, 32'h2, 1'b1, 1'b1);
    wr(5'd8, 32'h3, 1'b1, 1'b1);
    idle(2);
    @(negedge clock);
    check("b2b_w7", 1024'(word_of(bus.reg_q, 7)), 1024'(32'h2));
    check("b2b_w8", 1024'(word_of(bus.reg_q, 8)), 1024'(32'h3));
    check("b2b_count", 1024'(bus.wr_count), 1024'(16'd4));

    // Reset on the commit edge discards the pending write.
    do_reset();
    wr(5'd9, 32'hA5A5A5A5, 1'b0, 1'b0);
    do_reset();
    check_idle_state("squash");
    idle(1);
    @(negedge clock);
    check("squash_w9", 1024'(word_of(bus.reg_q, 9)), '0);

    // Fill every index on consecutive cycles.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h01010101, 1'b1, 1'b1);
    end
    idle(2);
    @(negedge clock);
    check("fill_w0", 1024'(word_of(bus.reg_q, 0)), '0);
    check("fill_w31", 1024'(word_of(bus.reg_q, 31)), 1024'(32'h1F1F1F1F));
    check("fill_count", 1024'(bus.wr_count), 1024'(16'd31));

    // Saturation of wr_count.
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      wr(5'd1, 32'(i), 1'b1, 1'b0);
    end
    idle(2);
    @(negedge clock);
    check("sat_preload", 1024'(bus.wr_count), 1024'(16'hFFFE));
    wr(5'd2, 32'h11111111, 1'b1, 1'b1);
    wr(5'd3, 32'h22222222, 1'b1, 1'b1);
    wr(5'd4, 32'h33333333, 1'b1, 1'b1);
    idle(3);
    @(negedge clock);
    check("sat_hold", 1024'(bus.wr_count), 1024'(16'hFFFF));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d outstanding want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clock and ctrl_reset.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: ctrl_reset  input  1  synchronous active-high reset.
REQ-004 Port: ctrl_writeEnable  input  1  write request, sampled each rising edge.
REQ-005 Port: ctrl_writeReg  input  5  destination register index.
REQ-006 Port: data_writeReg  input  32  write data.
REQ-007 Port: reg_q  output  1024  flat register contents, word i at bits [32*i+31:32*i]; feeds the per-register read-port inputs.
REQ-008 Port: write_pending  output  1  a write is held in the pending stage.
REQ-009 Port: wr_count  output  16  saturating count of committed writes.

Function
REQ-010 Storage SHALL be 32 registers of 32 bits, index 0..31.
REQ-011 Register 0 SHALL read as 32'h0 at all times; writes to index 0 SHALL be dropped and SHALL NOT set write_pending or increment wr_count.
REQ-012 Pending stage: at each rising edge, if ctrl_writeEnable=1 and ctrl_writeReg!=0, pend_valid<=1, pend_idx<=ctrl_writeReg, pend_data<=data_writeReg; otherwise pend_valid<=0.
REQ-013 Commit stage: at each rising edge, if pend_valid=1, register[pend_idx]<=pend_data and wr_count increments by 1.
REQ-014 Latency without bypass: data presented before edge N SHALL appear in reg_q after edge N+1 (two edges).
REQ-015 write_pending SHALL equal pend_valid.
REQ-016 Back-to-back writes, including to the same index, SHALL commit in issue order at one write per cycle; the later write wins.
REQ-017 Pending and commit stages SHALL operate concurrently: a new write can be captured on the same edge as the previous one commits.
REQ-018 wr_count SHALL saturate at 16'hFFFF and not wrap.
REQ-019 Indices 1..31 SHALL be written only through the commit stage; no other register changes on any edge.
REQ-020 reg_q SHALL be driven continuously, never high-impedance.

Reset
REQ-021 When ctrl_reset=1 at a rising edge: all 32 registers<=0, pend_valid<=0, pend_idx<=0, pend_data<=0, wr_count<=0.
REQ-022 Reset SHALL take priority over any write on the same edge; a write pending at that edge SHALL be discarded, not committed.
REQ-023 After reset: reg_q=0, write_pending=0, wr_count=0 until the first accepted write.

Configuration
REQ-024 Macro REGBANK_BYPASS_EN SHALL select write forwarding.
REQ-025 With REGBANK_BYPASS_EN defined: while pend_valid=1, reg_q word pend_idx SHALL combinationally show pend_data, so a write is visible after edge N (one edge); all other words show committed values.
REQ-026 Without REGBANK_BYPASS_EN: reg_q SHALL show committed values only, per REQ-014.
REQ-027 Commit timing, wr_count and write_pending SHALL be identical in both builds.

Verification
REQ-028 Reset, then write idx 5 = 32'hDEADBEEF for one cycle -> write_pending=1 after edge 1; reg_q[191:160]=32'hDEADBEEF after edge 2 (after edge 1 with bypass); wr_count=1.
REQ-029 Write idx 0 = 32'hFFFFFFFF -> reg_q[31:0] stays 0, write_pending stays 0, wr_count stays 0.
REQ-030 Consecutive writes idx 7 = 32'h1, then idx 7 = 32'h2, then idx 8 = 32'h3 -> after final commit word 7 = 32'h2, word 8 = 32'h3, wr_count=3.
REQ-031 Write idx 9 = 32'hA5A5A5A5, assert ctrl_reset on the next edge -> word 9 stays 0, write_pending=0, wr_count=0.
REQ-032 Preload wr_count to 16'hFFFE through 65534 writes, then issue 3 more writes -> wr_count holds 16'hFFFF.
REQ-033 Write all indices 1..31 with value (idx*32'h01010101) on consecutive cycles -> each word matches after its commit edge, word 0 = 0, with no cross-word corruption.
